// File: rtl/multdiv_wb_arbiter_pkg.sv
// Shared types and constants for the mult/div writeback arbiter.
package multdiv_wb_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHold = 2'd2
  } md_state_e;

  // Read-after-write or write-after-write hit against the pending destination; r0 never hits.
  function automatic logic rd_hazard(
    input logic [REG_W-1:0] pend_rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rd,
    input logic             we
  );
    return (pend_rd != REG_ZERO) &&
           ((rs1 == pend_rd) || (rs2 == pend_rd) || (we && (rd == pend_rd)));
  endfunction

endpackage

// File: rtl/multdiv_wb_arbiter_if.sv
// Pipeline-facing bundle of the arbiter: X-stage issue, multdiv result, W stage,
// D/X hazard operands and the regfile write port.
interface multdiv_wb_arbiter_if #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DATA_W = 32
);

  logic              md_start;
  logic [REG_W-1:0]  md_rd;
  logic              md_ready;
  logic [DATA_W-1:0] md_result;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  dx_rs1;
  logic [REG_W-1:0]  dx_rs2;
  logic [REG_W-1:0]  dx_rd;
  logic              dx_we;
  logic              rf_we;
  logic [REG_W-1:0]  rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              stall;
  logic              md_busy;

  // Pipeline / environment side.
  modport master (
    output md_start, md_rd, md_ready, md_result, wb_we, wb_rd, wb_data,
           dx_rs1, dx_rs2, dx_rd, dx_we,
    input  rf_we, rf_rd, rf_data, stall, md_busy
  );

  // Arbiter side.
  modport slave (
    input  md_start, md_rd, md_ready, md_result, wb_we, wb_rd, wb_data,
           dx_rs1, dx_rs2, dx_rd, dx_we,
    output rf_we, rf_rd, rf_data, stall, md_busy
  );

endinterface

// File: rtl/multdiv_wb_arbiter_pending_rd_reg.sv
// Destination register of the in-flight mult/div op: enable load, synchronous reset.
module pending_rd_reg #(
  parameter int unsigned Width = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  // Load on enable, clear on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_wb_arbiter.sv
// Tracks the single in-flight mult/div op, shares the regfile write port with the
// W stage (W always wins) and stalls the front-end on hazards and structural conflicts.
module multdiv_wb_arbiter
  import multdiv_wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_W  = multdiv_wb_arbiter_pkg::REG_W,
  parameter int unsigned DATA_W = multdiv_wb_arbiter_pkg::DATA_W
) (
  input logic             clock,
  input logic             reset,
  multdiv_wb_arbiter_if.slave bus
);

  md_state_e         state;
  logic [DATA_W-1:0] hold_data;
  logic              busy;
  logic [REG_W-1:0]  pend_rd;
  logic              accept;

  // An op is accepted only against the registered IDLE state.
  assign accept = (state == StIdle) && bus.md_start;

  pending_rd_reg #(
    .Width (REG_W)
  ) u_pending_rd (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .d     (bus.md_rd),
    .q     (pend_rd)
  );

  // Op lifecycle FSM; busy mirrors state != IDLE as a registered flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      hold_data <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.md_start) begin
            state <= StBusy;
            busy  <= 1'b1;
          end
        end
        StBusy: begin
          if (bus.md_ready) begin
            hold_data <= bus.md_result;
            state     <= StHold;
          end
        end
        StHold: begin
          // The W stage owns the port whenever it writes; drain on the first free cycle.
          if (!bus.wb_we) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Regfile write port mux: W stage first, then the held result (r0 suppressed).
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_rd   = bus.wb_rd;
    bus.rf_data = bus.wb_data;
    if (reset) begin
      bus.rf_we = 1'b0;
    end else if (bus.wb_we) begin
      bus.rf_we = 1'b1;
    end else if (state == StHold) begin
      bus.rf_we   = (pend_rd != REG_ZERO);
      bus.rf_rd   = pend_rd;
      bus.rf_data = hold_data;
    end
  end

  // Front-end stall: structural issue, pending-destination hazard, or result waiting in HOLD.
  always_comb begin
    bus.stall = 1'b0;
    if (!reset && (state != StIdle)) begin
      bus.stall = bus.md_start || (state == StHold) ||
                  rd_hazard(pend_rd, bus.dx_rs1, bus.dx_rs2, bus.dx_rd, bus.dx_we);
    end
  end

  assign bus.md_busy = busy && !reset;

endmodule
